// File: rtl/alu_issue_ctrl.sv
// Issue controller for a 32-bit combinational ALU: one command per 3 cycles,
// with an internal register file, result writeback and persistent N/Z/C flags.
module alu_issue_ctrl #(
    parameter int W     = 32,
    parameter int NREGS = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [3:0]    cmd_op,
    input  logic [AW-1:0] cmd_rd,
    input  logic [AW-1:0] cmd_rn,
    input  logic [AW-1:0] cmd_rm,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [W-1:0]  ld_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    output logic [3:0]    alu_opcode,
    output logic          alu_cin,
    input  logic [W-1:0]  alu_result,
    input  logic          alu_cout,
    input  logic          alu_neg,
    input  logic          alu_zero,
    output logic          wb_valid,
    output logic [AW-1:0] wb_addr,
    output logic [W-1:0]  wb_data,
    output logic          err,
    output logic          flag_n,
    output logic          flag_z,
    output logic          flag_c
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WB    = 2'd2
    } state_t;

    // What the retiring opcode does to the register file and the flags.
    typedef enum logic [1:0] {
        CLS_ARITH_C,   // write rd, update N/Z/C
        CLS_WRITE_NZ,  // write rd, update N/Z, hold C
        CLS_CMP,       // update N/Z only
        CLS_ILLEGAL    // no effect except err
    } op_class_t;

    function automatic op_class_t classify(input logic [3:0] op);
        op_class_t cls;
        if (op == 4'b0000 || op == 4'b0111) begin
            cls = CLS_ARITH_C;
        end else if (op == 4'b0011) begin
            cls = CLS_CMP;
        end else if (op > 4'b1000) begin
            cls = CLS_ILLEGAL;
        end else begin
            cls = CLS_WRITE_NZ;
        end
        return cls;
    endfunction

    state_t           state;
    state_t           state_next;
    op_class_t        op_class;
    logic             accept;
    logic             in_wb;
    logic [AW-1:0]    lat_rd;
    logic [W-1:0]     res_q;
    logic             cout_q;
    logic             neg_q;
    logic             zero_q;
    logic [W-1:0]     regs [NREGS];

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (cmd_valid) state_next = ISSUE;
            ISSUE:   state_next = WB;
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign cmd_ready = (state == IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign in_wb     = (state == WB);
    assign op_class  = classify(alu_opcode);

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        wb_valid = 1'b0;
        err      = 1'b0;
        if (in_wb) begin
            wb_valid = (op_class == CLS_ARITH_C) || (op_class == CLS_WRITE_NZ);
            err      = (op_class == CLS_ILLEGAL);
        end
    end

    assign wb_addr = lat_rd;
    assign wb_data = res_q;
    assign rd_data = regs[rd_addr];

    // ------------------------------------------------------------------
    // Command latch and ALU drive: operands are read at the handshake edge,
    // so the ALU sees stable inputs for the whole ISSUE cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_rd     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            alu_cin    <= 1'b0;
        end else if (accept) begin
            lat_rd     <= cmd_rd;
            alu_a      <= regs[cmd_rn];
            alu_b      <= regs[cmd_rm];
            alu_opcode <= cmd_op;
            alu_cin    <= flag_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q  <= '0;
            cout_q <= 1'b0;
            neg_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (state == ISSUE) begin
            res_q  <= alu_result;
            cout_q <= alu_cout;
            neg_q  <= alu_neg;
            zero_q <= alu_zero;
        end
    end

    // ------------------------------------------------------------------
    // Persistent flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_n <= 1'b0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
        end else if (in_wb) begin
            unique case (op_class)
                CLS_ARITH_C: begin
                    flag_n <= neg_q;
                    flag_z <= zero_q;
                    flag_c <= cout_q;
                end
                CLS_WRITE_NZ, CLS_CMP: begin
                    flag_n <= neg_q;
                    flag_z <= zero_q;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    // NOTE: the register file is small and architecturally visible, so it is
    // cleared by reset like any other state rather than left as a RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (ld_en) begin
                regs[ld_addr] <= ld_data;
            end
            // Placed after the load so a writeback to the same register wins.
            if (wb_valid) begin
                regs[lat_rd] <= res_q;
            end
        end
    end

endmodule
